// File: rtl/norm_pkg.sv
// Shared constants and types for the block-floating-point normaliser.
package norm_pkg;

    localparam logic [1:0] ADDR_CTRL       = 2'd0;
    localparam logic [1:0] ADDR_LAST_SHIFT = 2'd1;
    localparam logic [1:0] ADDR_BLKCNT     = 2'd2;
    localparam logic [1:0] ADDR_BLOCK_N    = 2'd3;

    localparam logic ENABLE_RST   = 1'b1;
    localparam int   NORM_SHIFT_W = 4;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_sel_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter; an all-zero input reports 0 so that
// an empty block is passed through unshifted.
module norm_lzc #(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = 4
) (
    input  logic [DATA_W-1:0]  value,
    output logic [SHIFT_W-1:0] count
);

    logic found;

    // Scan from the MSB down and latch the position of the first set bit.
    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = SHIFT_W'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/norm_block.sv
// Streaming block-floating-point normaliser with ping-pong sample banks.
// Optional macro NORM_STATUS_EN adds the LAST_SHIFT and BLKCNT status
// registers; without it those addresses read 0.
module norm_block
    import norm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BLOCK_N = 16,
    parameter int SHIFT_W = NORM_SHIFT_W
) (
    input  logic              clk_proc,
    input  logic              reset_n,
    input  logic              in_fv,
    input  logic              in_dv,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_fv,
    output logic              out_dv,
    output logic [DATA_W-1:0] out_data,
    input  logic [1:0]        addr_rel_i,
    input  logic              wr_i,
    input  logic [31:0]       datawr_i,
    input  logic              rd_i,
    output logic [31:0]       datard_o
);

    localparam int IDX_W = $clog2(BLOCK_N);
    localparam int CNT_W = IDX_W + 1;

    logic              accept;
    logic              fv_d;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] run_max;
    bank_sel_t         fill_sel;
    logic [DATA_W-1:0] mem [2][BLOCK_N];

    logic              full_close;
    logic              flush_close;
    logic              close;
    logic [DATA_W-1:0] close_max;
    logic [CNT_W-1:0]  close_len;
    logic [SHIFT_W-1:0] lz;
    logic [SHIFT_W-1:0] close_shift;

    rd_state_t          rd_state;
    bank_sel_t          rd_sel;
    logic [IDX_W-1:0]   rd_idx;
    logic [CNT_W-1:0]   rd_len;
    logic [SHIFT_W-1:0] rd_shift;

    logic               enable;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign accept      = in_fv & in_dv;
    assign unused_bits = ^datawr_i[31:1];

    // Decide when the fill bank closes and what length/shift it carries.
    // A full block closes on the edge that accepts its last sample, so that
    // sample takes part in the maximum directly from in_data.
    always_comb begin
        full_close  = accept && (cnt == CNT_W'(BLOCK_N - 1));
        flush_close = fv_d && !in_fv && (cnt != '0);
        close       = full_close | flush_close;
        close_max   = run_max;
        if (full_close && (in_data > run_max)) begin
            close_max = in_data;
        end
        close_len   = full_close ? CNT_W'(BLOCK_N) : cnt;
        close_shift = enable ? lz : '0;
    end

    norm_lzc #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) u_lzc (
        .value (close_max),
        .count (lz)
    );

    // Sample storage: accepted samples land in the current fill bank.
    always_ff @(posedge clk_proc) begin
        if (accept) begin
            mem[fill_sel][cnt[IDX_W-1:0]] <= in_data;
        end
    end

    // Fill side: count samples, track the running max, swap banks on close.
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            fv_d     <= 1'b0;
            cnt      <= '0;
            run_max  <= '0;
            fill_sel <= BANK_0;
        end else begin
            fv_d <= in_fv;
            if (close) begin
                cnt      <= '0;
                run_max  <= '0;
                fill_sel <= (fill_sel == BANK_0) ? BANK_1 : BANK_0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
                if (in_data > run_max) begin
                    run_max <= in_data;
                end
            end
        end
    end

    // Readout side: stream the closed bank out shifted, one sample per cycle.
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= RD_IDLE;
            rd_sel   <= BANK_0;
            rd_idx   <= '0;
            rd_len   <= '0;
            rd_shift <= '0;
            out_fv   <= 1'b0;
            out_dv   <= 1'b0;
            out_data <= '0;
        end else begin
            out_fv <= in_fv | close | (rd_state == RD_RUN);
            if (rd_state == RD_RUN) begin
                out_dv   <= 1'b1;
                out_data <= mem[rd_sel][rd_idx] << rd_shift;
            end else begin
                out_dv   <= 1'b0;
                out_data <= '0;
            end
            if (close) begin
                rd_state <= RD_RUN;
                rd_sel   <= fill_sel;
                rd_idx   <= '0;
                rd_len   <= close_len;
                rd_shift <= close_shift;
            end else if (rd_state == RD_RUN) begin
                rd_idx <= rd_idx + 1'b1;
                if ((CNT_W'(rd_idx) + 1'b1) == rd_len) begin
                    rd_state <= RD_IDLE;
                end
            end
        end
    end

    // Control register: ENABLE is sampled by the datapath only at close.
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            enable <= ENABLE_RST;
        end else if (wr_i && (addr_rel_i == ADDR_CTRL)) begin
            enable <= datawr_i[0];
        end
    end

`ifdef NORM_STATUS_EN
    logic [SHIFT_W-1:0] last_shift;
    logic [31:0]        blk_cnt;

    // Status capture: remember the latest shift and count closed blocks.
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            last_shift <= '0;
            blk_cnt    <= '0;
        end else if (close) begin
            last_shift <= close_shift;
            blk_cnt    <= blk_cnt + 32'd1;
        end
    end
`endif

    // Register read mux.
    always_comb begin
        rd_mux = '0;
        case (addr_rel_i)
            ADDR_CTRL:       rd_mux = {31'd0, enable};
`ifdef NORM_STATUS_EN
            ADDR_LAST_SHIFT: rd_mux = 32'(last_shift);
            ADDR_BLKCNT:     rd_mux = blk_cnt;
`else
            ADDR_LAST_SHIFT: rd_mux = '0;
            ADDR_BLKCNT:     rd_mux = '0;
`endif
            ADDR_BLOCK_N:    rd_mux = 32'(BLOCK_N);
            default:         rd_mux = '0;
        endcase
    end

    // Registered read data, held between read strobes.
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            datard_o <= '0;
        end else if (rd_i) begin
            datard_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_norm_block.sv
// Directed self-checking bench for norm_block.
module tb_norm_block;

    logic        clk_proc = 1'b0;
    logic        reset_n  = 1'b0;
    logic        in_fv    = 1'b0;
    logic        in_dv    = 1'b0;
    logic [15:0] in_data  = '0;
    logic        out_fv;
    logic        out_dv;
    logic [15:0] out_data;
    logic [1:0]  addr_rel_i = '0;
    logic        wr_i       = 1'b0;
    logic [31:0] datawr_i   = '0;
    logic        rd_i       = 1'b0;
    logic [31:0] datard_o;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [15:0] cap_q[$];
    int          cap_cyc[$];

`ifdef NORM_STATUS_EN
    localparam bit STATUS_ON = 1'b1;
`else
    localparam bit STATUS_ON = 1'b0;
`endif

    norm_block #(
        .DATA_W  (16),
        .BLOCK_N (16),
        .SHIFT_W (4)
    ) dut (
        .clk_proc   (clk_proc),
        .reset_n    (reset_n),
        .in_fv      (in_fv),
        .in_dv      (in_dv),
        .in_data    (in_data),
        .out_fv     (out_fv),
        .out_dv     (out_dv),
        .out_data   (out_data),
        .addr_rel_i (addr_rel_i),
        .wr_i       (wr_i),
        .datawr_i   (datawr_i),
        .rd_i       (rd_i),
        .datard_o   (datard_o)
    );

    always #5 clk_proc = ~clk_proc;

    always @(posedge clk_proc) cycle <= cycle + 1;

    // Record every emitted sample together with the cycle it appeared in.
    always @(negedge clk_proc) begin
        if (out_dv) begin
            cap_q.push_back(out_data);
            cap_cyc.push_back(cycle);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_sample(input logic [15:0] v, input int gap, output int drv_cyc);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_proc); #1;
            in_dv = 1'b0;
        end
        @(posedge clk_proc); #1;
        in_dv   = 1'b1;
        in_data = v;
        drv_cyc = cycle;
    endtask

    task automatic end_samples();
        @(posedge clk_proc); #1;
        in_dv = 1'b0;
    endtask

    task automatic start_frame();
        cap_q.delete();
        cap_cyc.delete();
        @(posedge clk_proc); #1;
        in_fv = 1'b1;
        in_dv = 1'b0;
    endtask

    task automatic end_frame();
        @(posedge clk_proc); #1;
        in_fv = 1'b0;
        in_dv = 1'b0;
        repeat (4) @(posedge clk_proc);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk_proc); #1;
        addr_rel_i = a;
        datawr_i   = d;
        wr_i       = 1'b1;
        @(posedge clk_proc); #1;
        wr_i = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] v);
        @(posedge clk_proc); #1;
        addr_rel_i = a;
        rd_i       = 1'b1;
        @(posedge clk_proc); #1;
        rd_i = 1'b0;
        v    = datard_o;
    endtask

    task automatic wait_outputs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_proc); #1;
            if (cap_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        #3;
        checks++; if (out_fv !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_fv got=%b required=0", out_fv); end
        checks++; if (out_dv !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_dv got=%b required=0", out_dv); end
        checks++; if (out_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%h required=0000", out_data); end
        checks++; if (datard_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_datard got=%h required=0", datard_o); end
        repeat (3) @(posedge clk_proc);
        #1 reset_n = 1'b1;
        reg_read(2'd3, v);
        checks++; if (v !== 32'd16) begin failures++; $display("[TB] FAIL reg_block_n got=%0d required=16", v); end
        reg_read(2'd0, v);
        checks++; if (v !== 32'd1) begin failures++; $display("[TB] FAIL reset_ctrl got=%h required=1", v); end
        reg_read(2'd2, v);
        checks++; if (v !== 32'd0) begin failures++; $display("[TB] FAIL reset_blkcnt got=%0d required=0", v); end
    endtask

    task automatic test_block_random();
        int d;
        bit ok;
        logic [15:0] e;
        logic [31:0] v;
        start_frame();
        @(negedge clk_proc);
        checks++; if (out_fv !== 1'b0) begin failures++; $display("[TB] FAIL fv_rise_early got=%b required=0", out_fv); end
        @(negedge clk_proc);
        checks++; if (out_fv !== 1'b1) begin failures++; $display("[TB] FAIL fv_rise got=%b required=1", out_fv); end
        for (int i = 0; i < 16; i++) begin
            drive_sample((i < 15) ? 16'(i + 1) : 16'h00F0, int'($urandom_range(0, 1)), d);
        end
        end_samples();
        wait_outputs(16, 100, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL rand_timeout got=%0d required=16", cap_q.size()); end
        for (int i = 0; i < 16; i++) begin
            e = (i < 15) ? 16'((i + 1) * 256) : 16'hF000;
            checks++; if (cap_q[i] !== e) begin failures++; $display("[TB] FAIL rand_data[%0d] got=%h required=%h", i, cap_q[i], e); end
        end
        for (int i = 1; i < 16; i++) begin
            checks++; if (cap_cyc[i] !== cap_cyc[0] + i) begin failures++; $display("[TB] FAIL rand_contig[%0d] got=%0d required=%0d", i, cap_cyc[i], cap_cyc[0] + i); end
        end
        checks++; if (cap_cyc[0] !== d + 2) begin failures++; $display("[TB] FAIL rand_latency got=%0d required=%0d", cap_cyc[0], d + 2); end
        end_frame();
        reg_read(2'd1, v);
        checks++; if (v !== (STATUS_ON ? 32'd8 : 32'd0)) begin failures++; $display("[TB] FAIL rand_last_shift got=%0d required=%0d", v, STATUS_ON ? 8 : 0); end
        reg_read(2'd2, v);
        checks++; if (v !== (STATUS_ON ? 32'd1 : 32'd0)) begin failures++; $display("[TB] FAIL rand_blkcnt got=%0d required=%0d", v, STATUS_ON ? 1 : 0); end
    endtask

    task automatic test_partial();
        int d;
        bit ok;
        logic [31:0] v;
        start_frame();
        for (int i = 0; i < 15; i++) drive_sample(16'h0003, 0, d);
        @(posedge clk_proc); #1;
        in_dv = 1'b0;
        in_fv = 1'b0;
        wait_outputs(15, 100, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL part_timeout got=%0d required=15", cap_q.size()); end
        checks++; if (out_fv !== 1'b1) begin failures++; $display("[TB] FAIL part_fv_last got=%b required=1", out_fv); end
        @(negedge clk_proc); #1;
        checks++; if (out_fv !== 1'b0) begin failures++; $display("[TB] FAIL part_fv_drop got=%b required=0", out_fv); end
        repeat (5) @(posedge clk_proc);
        checks++; if (cap_q.size() !== 15) begin failures++; $display("[TB] FAIL part_count got=%0d required=15", cap_q.size()); end
        for (int i = 0; i < 15; i++) begin
            checks++; if (cap_q[i] !== 16'hC000) begin failures++; $display("[TB] FAIL part_data[%0d] got=%h required=c000", i, cap_q[i]); end
        end
        reg_read(2'd1, v);
        checks++; if (v !== (STATUS_ON ? 32'd14 : 32'd0)) begin failures++; $display("[TB] FAIL part_last_shift got=%0d required=%0d", v, STATUS_ON ? 14 : 0); end
        reg_read(2'd2, v);
        checks++; if (v !== (STATUS_ON ? 32'd2 : 32'd0)) begin failures++; $display("[TB] FAIL part_blkcnt got=%0d required=%0d", v, STATUS_ON ? 2 : 0); end
    endtask

    task automatic test_zero_block();
        int d;
        bit ok;
        logic [31:0] v;
        start_frame();
        for (int i = 0; i < 16; i++) drive_sample(16'h0000, 0, d);
        end_samples();
        wait_outputs(16, 100, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL zero_timeout got=%0d required=16", cap_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_q[i] !== 16'h0000) begin failures++; $display("[TB] FAIL zero_data[%0d] got=%h required=0000", i, cap_q[i]); end
        end
        end_frame();
        reg_read(2'd1, v);
        checks++; if (v !== 32'd0) begin failures++; $display("[TB] FAIL zero_last_shift got=%0d required=0", v); end
    endtask

    task automatic test_disable();
        int d;
        bit ok;
        logic [31:0] v;
        reg_write(2'd0, 32'h0);
        reg_read(2'd0, v);
        checks++; if (v !== 32'd0) begin failures++; $display("[TB] FAIL dis_ctrl_read got=%h required=0", v); end
        start_frame();
        for (int i = 0; i < 16; i++) drive_sample(16'(i + 1), 0, d);
        end_samples();
        wait_outputs(16, 100, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL dis_timeout got=%0d required=16", cap_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_q[i] !== 16'(i + 1)) begin failures++; $display("[TB] FAIL dis_data[%0d] got=%h required=%h", i, cap_q[i], 16'(i + 1)); end
        end
        end_frame();
        reg_write(2'd2, 32'h55);
        reg_read(2'd2, v);
        checks++; if (v !== (STATUS_ON ? 32'd4 : 32'd0)) begin failures++; $display("[TB] FAIL ro_write_ignored got=%0d required=%0d", v, STATUS_ON ? 4 : 0); end
        reg_write(2'd0, 32'hFFFF_FFFF);
        reg_read(2'd0, v);
        checks++; if (v !== 32'd1) begin failures++; $display("[TB] FAIL ctrl_restore got=%h required=1", v); end
    endtask

    task automatic test_back_to_back();
        int d;
        int d_first;
        bit ok;
        logic [15:0] s;
        logic [15:0] e;
        d_first = 0;
        start_frame();
        for (int i = 0; i < 48; i++) begin
            case (i / 16)
                0:       s = 16'h0010 + 16'(i % 16);
                1:       s = 16'h0100 + 16'(i % 16);
                default: s = 16'h4000 + 16'(i % 16);
            endcase
            drive_sample(s, 0, d);
            if (i == 15) d_first = d;
        end
        end_samples();
        wait_outputs(48, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL b2b_timeout got=%0d required=48", cap_q.size()); end
        for (int i = 0; i < 48; i++) begin
            case (i / 16)
                0:       e = 16'h8000 + 16'((i % 16) * 16'h0800);
                1:       e = 16'h8000 + 16'((i % 16) * 16'h0080);
                default: e = 16'h8000 + 16'((i % 16) * 2);
            endcase
            checks++; if (cap_q[i] !== e) begin failures++; $display("[TB] FAIL b2b_data[%0d] got=%h required=%h", i, cap_q[i], e); end
        end
        for (int i = 1; i < 48; i++) begin
            checks++; if (cap_cyc[i] !== cap_cyc[0] + i) begin failures++; $display("[TB] FAIL b2b_contig[%0d] got=%0d required=%0d", i, cap_cyc[i], cap_cyc[0] + i); end
        end
        checks++; if (cap_cyc[0] !== d_first + 2) begin failures++; $display("[TB] FAIL b2b_latency got=%0d required=%0d", cap_cyc[0], d_first + 2); end
        end_frame();
        repeat (16) @(posedge clk_proc);
        checks++; if (cap_q.size() !== 48) begin failures++; $display("[TB] FAIL b2b_count got=%0d required=48", cap_q.size()); end
    endtask

    task automatic test_reset_mid_block();
        int d;
        bit ok;
        logic [15:0] e;
        logic [31:0] v;
        start_frame();
        for (int i = 0; i < 7; i++) drive_sample(16'h0100, 0, d);
        @(posedge clk_proc); #1;
        in_dv   = 1'b0;
        in_fv   = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (out_fv !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_fv got=%b required=0", out_fv); end
        checks++; if (out_dv !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_dv got=%b required=0", out_dv); end
        checks++; if (out_data !== 16'h0) begin failures++; $display("[TB] FAIL rst_mid_data got=%h required=0000", out_data); end
        repeat (2) @(posedge clk_proc);
        #1 reset_n = 1'b1;
        repeat (30) @(posedge clk_proc);
        checks++; if (cap_q.size() !== 0) begin failures++; $display("[TB] FAIL rst_mid_no_readout got=%0d required=0", cap_q.size()); end
        start_frame();
        for (int i = 0; i < 16; i++) drive_sample(16'h0020 + 16'(i), 0, d);
        end_samples();
        wait_outputs(16, 100, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL fresh_timeout got=%0d required=16", cap_q.size()); end
        for (int i = 0; i < 16; i++) begin
            e = 16'h8000 + 16'(i * 16'h0400);
            checks++; if (cap_q[i] !== e) begin failures++; $display("[TB] FAIL fresh_data[%0d] got=%h required=%h", i, cap_q[i], e); end
        end
        end_frame();
        reg_read(2'd2, v);
        checks++; if (v !== (STATUS_ON ? 32'd1 : 32'd0)) begin failures++; $display("[TB] FAIL fresh_blkcnt got=%0d required=%0d", v, STATUS_ON ? 1 : 0); end
        reg_read(2'd1, v);
        checks++; if (v !== (STATUS_ON ? 32'd10 : 32'd0)) begin failures++; $display("[TB] FAIL fresh_last_shift got=%0d required=%0d", v, STATUS_ON ? 10 : 0); end
    endtask

    initial begin
        test_reset();
        test_block_random();
        test_partial();
        test_zero_block();
        test_disable();
        test_back_to_back();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/norm_block.md
Name: norm_block

Overview:
- Streaming block-floating-point normaliser for the video/process pipeline; sits between two fv/dv/data stream stages.
- Groups incoming samples into blocks of BLOCK_N and finds the block maximum.
- Left-shifts every sample of the block by the leading-zero count of that maximum, so the largest sample gets its MSB set.
- Ping-pong buffering sustains one sample per cycle; a small slave register port gives control and status access.

Parameters:
- DATA_W, 16, sample width of in_data and out_data.
- BLOCK_N, 16, samples per block (power of two, 2..64).
- SHIFT_W, 4, width of the shift value; equals clog2(DATA_W).

Ports:
- clk_proc in 1: single clock; everything is rising-edge.
- reset_n in 1: asynchronous active-low reset.
- in_fv in 1: input frame valid.
- in_dv in 1: input sample valid; a sample is accepted when in_fv & in_dv.
- in_data in DATA_W: input sample, unsigned.
- out_fv out 1: output frame valid.
- out_dv out 1: output sample valid.
- out_data out DATA_W: normalised sample.
- addr_rel_i in 2: register address.
- wr_i in 1: register write strobe.
- datawr_i in 32: register write data.
- rd_i in 1: register read strobe.
- datard_o out 32: register read data.

Behaviour:
- Reset (async, reset_n=0): out_fv, out_dv and datard_o are 0; out_data is 0; both banks are marked empty; fill count is 0; running max is 0; ENABLE is 1; block counter is 0.
- Fill:
  - Each accepted sample is written to the fill bank at index cnt, and the running max is updated.
  - When cnt reaches BLOCK_N, the block is closed.
  - A falling in_fv with cnt>0 also closes the block as a partial block of cnt samples.
  - A falling in_fv with cnt=0 closes nothing.
- Close:
  - shift = leading-zero count of the block max; max=0 gives shift 0; ENABLE=0 forces shift 0.
  - The banks swap; the readout bank is loaded with (length, shift); cnt and max are cleared.
  - A sample accepted in the same cycle as the close goes to the new fill bank.
- Readout:
  - Starts the cycle after close.
  - Emits one sample per cycle for exactly length cycles, with out_dv=1 and out_data = (sample << shift) truncated to DATA_W.
  - Samples are emitted in arrival order. Latency from the last accepted sample to the first out_dv is 2 cycles.
- Bank sizing: readout (≤BLOCK_N cycles) always completes before the next full block closes, so no overflow is possible. A partial-block flush followed immediately by a new frame is handled by the ping-pong banks.
- out_fv:
  - Rises 1 cycle after in_fv rises.
  - After in_fv falls, stays high until the cycle after the last readout sample of that frame, then drops.
  - Two frames separated by a gap produce two separate out_fv pulses.
- Registers:
  - 0 CTRL (RW): bit0 = ENABLE; other bits read 0.
  - 1 LAST_SHIFT (RO): shift of the most recent closed block.
  - 2 BLKCNT (RO): count of closed blocks; 32-bit, wraps.
  - 3 BLOCK_N (RO).
  - Writes take effect on the next cycle; an ENABLE change applies at the next block close.
  - datard_o is registered, valid the cycle after rd_i, and holds its value otherwise.
  - Writes to RO registers are ignored.

Optional Feature:
- NORM_STATUS_EN defined: LAST_SHIFT and BLKCNT are implemented as described.
- NORM_STATUS_EN undefined: registers 1 and 2 read 0 and their logic is removed. CTRL, BLOCK_N and the datapath are unchanged.

Decomposition:
- norm_pkg holds the register address constants (CTRL, LAST_SHIFT, BLKCNT, BLOCK_N), the ENABLE reset value, the shift width and a bank-select typedef.
- One sub-module, norm_lzc: combinational leading-zero counter, DATA_W input to SHIFT_W output, with a zero input giving 0.

Test Plan:
- 16 samples, values 1..15 then 0x00F0, dv random at about 50%: max 0x00F0 gives shift 8; outputs are 0x0100..0x0F00 then 0xF000; 16 contiguous out_dv; LAST_SHIFT=8; BLKCNT=1.
- Partial block: 15 samples of 0x0003, then fv falls: 15 outputs of 0xC000 (shift 14); out_fv falls the cycle after the last one.
- All-zero block of 16: outputs all 0, shift 0.
- Write CTRL=0, then one block with max 0x0010: outputs equal inputs; read CTRL returns 0 the cycle after rd_i.
- Back-to-back full-rate blocks (dv always 1, 48 samples): 48 outputs in order, no loss, with out_dv continuous after the initial 2-cycle latency.
- reset_n pulsed low mid-block (after 7 samples): outputs go to 0 immediately and no readout occurs; the next 16 samples form a fresh block with correct shift.
